// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage behind the ALU. It accepts one load or store at a time and
//   drives one request/acknowledge data-bus transaction for it. Load data is
//   aligned and sign- or zero-extended before it goes to writeback. Faults are
//   reported on o_Fault and never trap.
//
// Ports
//   i_Clock, i_Reset         clock (rising edge), asynchronous active-high reset
//   i_Valid / o_Ready        execute handshake; an op transfers on i_Valid && o_Ready
//   i_IsStore, i_Funct3      operation kind and access size
//   i_Address, i_StoreData   effective address and rs2 value
//   i_Rd                     load destination register
//   o_MemReq .. o_MemByteEn  bus request: word address, write data, byte enables
//   i_MemAck, i_MemRdata     bus completion and read word
//   o_Done .. o_FaultAddr    one-cycle completion record for writeback
//
// Parameter
//   ACK_TIMEOUT  number of request cycles to wait for i_MemAck before a bus
//                timeout fault is reported; 0 means wait forever

module load_store_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic        i_IsStore,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    input  logic [4:0]  i_Rd,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr,
    output logic [31:0] o_MemWdata,
    output logic [3:0]  o_MemByteEn,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemRdata,
    output logic        o_Done,
    output logic        o_DoneWrite,
    output logic [4:0]  o_DoneRd,
    output logic [31:0] o_DoneData,
    output logic [1:0]  o_Fault,
    output logic [31:0] o_FaultAddr
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] FLT_OK      = 2'b00;
    localparam logic [1:0] FLT_MISALGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL = 2'b11;

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    // Counter value seen during the last permitted request cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    // Store data is replicated across every lane the access could hit, so
    // the bus only needs byte enables to pick the target bytes.
    function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   fmt_wdata = {4{d[7:0]}};
            2'b01:   fmt_wdata = {2{d[15:0]}};
            default: fmt_wdata = d;
        endcase
    endfunction

    function automatic logic [3:0] fmt_byteen(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   fmt_byteen = 4'b0001 << a;
            2'b01:   fmt_byteen = a[1] ? 4'b1100 : 4'b0011;
            default: fmt_byteen = 4'b1111;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to the access size.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd_word);
        logic [31:0] lane;
        lane = rd_word >> {a, 3'b000};
        case (f3)
            3'b000:  fmt_load = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt_load = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt_load = {24'h0, lane[7:0]};
            3'b101:  fmt_load = {16'h0, lane[15:0]};
            default: fmt_load = lane;
        endcase
    endfunction

    function automatic logic [1:0] check_fault(input logic st, input logic [2:0] f3,
                                               input logic [1:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (st && f3[2]))
            check_fault = FLT_ILLEGAL;
        else if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00))
            check_fault = FLT_MISALGN;
        else
            check_fault = FLT_OK;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_store;
    logic [2:0]       funct3;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [3:0]       byteen;
    logic [4:0]       rd;
    logic [1:0]       fault;
    logic [31:0]      ld_data;
    logic [1:0]       acc_fault;

    assign acc_fault = check_fault(i_IsStore, i_Funct3, i_Address[1:0]);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_store <= 1'b0;
            funct3   <= 3'b000;
            addr     <= 32'h0;
            wdata    <= 32'h0;
            byteen   <= 4'h0;
            rd       <= 5'h0;
            fault    <= FLT_OK;
            ld_data  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_Valid) begin
                        is_store <= i_IsStore;
                        funct3   <= i_Funct3;
                        addr     <= i_Address;
                        wdata    <= fmt_wdata(i_Funct3, i_StoreData);
                        byteen   <= fmt_byteen(i_Funct3, i_Address[1:0]);
                        rd       <= i_Rd;
                        fault    <= acc_fault;
                        ld_data  <= 32'h0;
                        cnt      <= '0;
                        state    <= (acc_fault != FLT_OK) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An ack on the final permitted cycle still completes normally.
                    if (i_MemAck) begin
                        if (!is_store)
                            ld_data <= fmt_load(funct3, addr[1:0], i_MemRdata);
                        state <= ST_DONE;
                    end else if (ACK_TIMEOUT != 0 && cnt == CNT_LAST) begin
                        fault <= FLT_TIMEOUT;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is gated by the reset input itself so that it reads 0 while reset
    // is asserted, even though the state is already IDLE.
    assign o_Ready     = (state == ST_IDLE) && !i_Reset;
    assign o_MemReq    = (state == ST_REQ);
    assign o_MemWe     = o_MemReq && is_store;
    assign o_MemAddr   = o_MemReq ? {addr[31:2], 2'b00} : 32'h0;
    assign o_MemWdata  = (o_MemReq && is_store) ? wdata : 32'h0;
    assign o_MemByteEn = o_MemReq ? byteen : 4'h0;

    assign o_Done      = (state == ST_DONE);
    assign o_DoneWrite = o_Done && !is_store && (fault == FLT_OK) && (rd != 5'd0);
    assign o_DoneRd    = o_Done ? rd : 5'd0;
    assign o_DoneData  = o_Done ? ld_data : 32'h0;
    assign o_Fault     = o_Done ? fault : FLT_OK;
    assign o_FaultAddr = o_Done ? addr : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done;
    logic        done_write;
    logic [4:0]  done_rd;
    logic [31:0] done_data;
    logic [1:0]  fault;
    logic [31:0] fault_addr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .o_Ready(ready),
        .i_IsStore(is_store), .i_Funct3(funct3), .i_Address(address),
        .i_StoreData(store_data), .i_Rd(rd),
        .o_MemReq(mem_req), .o_MemWe(mem_we), .o_MemAddr(mem_addr),
        .o_MemWdata(mem_wdata), .o_MemByteEn(mem_byteen),
        .i_MemAck(mem_ack), .i_MemRdata(mem_rdata),
        .o_Done(done), .o_DoneWrite(done_write), .o_DoneRd(done_rd),
        .o_DoneData(done_data), .o_Fault(fault), .o_FaultAddr(fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge, then drop i_Valid.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] r);
        valid = 1'b1; is_store = st; funct3 = f3; address = a; store_data = d; rd = r;
        step();
        valid = 1'b0;
    endtask

    // Load acked in its first request cycle; returns sampled during the DONE cycle.
    task automatic quick_load(input logic [2:0] f3, input logic [31:0] a,
                              input logic [4:0] r, input logic [31:0] word);
        issue(1'b0, f3, a, 32'h0, r);
        mem_ack = 1'b1; mem_rdata = word;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        address = 32'h0; store_data = 32'h0; rd = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        step();
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_req", 32'(mem_req), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        #1;
        check("release_ready", 32'(ready), 32'd1);

        // SB to 0x1003
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd0);
        check("sb_req", 32'(mem_req), 32'd1);
        check("sb_we", 32'(mem_we), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_1000);
        check("sb_byteen", 32'(mem_byteen), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_ready_busy", 32'(ready), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sb_done", 32'(done), 32'd1);
        check("sb_fault", 32'(fault), 32'd0);
        check("sb_dwrite", 32'(done_write), 32'd0);
        check("sb_ddata", done_data, 32'h0);
        check("sb_req_off", 32'(mem_req), 32'd0);
        step();
        check("sb_idle_done", 32'(done), 32'd0);
        check("sb_idle_ready", 32'(ready), 32'd1);

        // SH to 0x1002
        issue(1'b1, 3'b001, 32'h0000_1002, 32'h1234_ABCD, 5'd0);
        check("sh_byteen", 32'(mem_byteen), 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        step();

        // LH 0x2002 rd 5
        issue(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd5);
        check("lh_we", 32'(mem_we), 32'd0);
        check("lh_byteen", 32'(mem_byteen), 32'hC);
        mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
        step();
        mem_ack = 1'b0;
        check("lh_data", done_data, 32'hFFFF_8001);
        check("lh_dwrite", 32'(done_write), 32'd1);
        check("lh_rd", 32'(done_rd), 32'd5);
        step();

        quick_load(3'b101, 32'h0000_2002, 5'd5, 32'h8001_1234);
        check("lhu_data", done_data, 32'h0000_8001);
        step();
        quick_load(3'b000, 32'h0000_2001, 5'd6, 32'h8001_1234);
        check("lb_data", done_data, 32'h0000_0012);
        check("lb_rd", 32'(done_rd), 32'd6);
        step();
        quick_load(3'b000, 32'h0000_2003, 5'd6, 32'h8001_1234);
        check("lb_neg_data", done_data, 32'hFFFF_FF80);
        step();

        // Misaligned LW
        issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd4);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_done", 32'(done), 32'd1);
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_faddr", fault_addr, 32'h0000_3001);
        check("mis_dwrite", 32'(done_write), 32'd0);
        step();
        check("mis_ready", 32'(ready), 32'd1);

        // Illegal funct3 011
        issue(1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd4);
        check("ill_done", 32'(done), 32'd1);
        check("ill_fault", 32'(fault), 32'd3);
        step();
        // Store with funct3 110 at odd address: illegal beats misaligned
        issue(1'b1, 3'b110, 32'h0000_1001, 32'h0, 5'd0);
        check("ill_prio_fault", 32'(fault), 32'd3);
        check("ill_prio_req", 32'(mem_req), 32'd0);
        step();

        // Timeout: never ack
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
            step();
        end
        check("to_req_off", 32'(mem_req), 32'd0);
        check("to_done", 32'(done), 32'd1);
        check("to_fault", 32'(fault), 32'd2);
        check("to_dwrite", 32'(done_write), 32'd0);
        check("to_ddata", done_data, 32'h0);
        step();

        // Ack on the 4th request cycle wins over timeout
        issue(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd7);
        step(); step(); step();
        check("ack4_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        check("ack4_done", 32'(done), 32'd1);
        check("ack4_fault", 32'(fault), 32'd0);
        check("ack4_data", done_data, 32'hDEAD_BEEF);
        check("ack4_dwrite", 32'(done_write), 32'd1);
        step();

        // LW rd 0 with three wait cycles, next op held valid during it
        issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd0);
        valid = 1'b1; is_store = 1'b0; funct3 = 3'b000; address = 32'h0000_6000; rd = 5'd9;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd0_req%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("rd0_addr%0d", i), mem_addr, 32'h0000_5000);
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
            end
            step();
        end
        mem_ack = 1'b0;
        check("rd0_done", 32'(done), 32'd1);
        check("rd0_dwrite", 32'(done_write), 32'd0);
        check("rd0_ready", 32'(ready), 32'd0);
        step();
        check("bb_ready", 32'(ready), 32'd1);
        check("bb_req_pre", 32'(mem_req), 32'd0);
        step();
        valid = 1'b0;
        check("bb_req", 32'(mem_req), 32'd1);
        check("bb_addr", mem_addr, 32'h0000_6000);
        mem_ack = 1'b1; mem_rdata = 32'h0000_00F0;
        step();
        mem_ack = 1'b0;
        check("bb_data", done_data, 32'hFFFF_FFF0);
        check("bb_rd", 32'(done_rd), 32'd9);
        step();

        // Reset in the 2nd request cycle
        issue(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd8);
        step();
        check("rr_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1; mem_ack = 1'b1;
        #1;
        check("rr_req", 32'(mem_req), 32'd0);
        check("rr_ready", 32'(ready), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        step();
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        check("rr_ready_after", 32'(ready), 32'd1);
        check("rr_done_after", 32'(done), 32'd0);
        step();
        check("rr_done_later", 32'(done), 32'd0);
        check("rr_req_later", 32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
